// File: rtl/unsigned_sequential_multiplier_pkg.sv
// Shared types and elaboration-time helpers for the sequential shift-add multiplier.
// Packages cannot be parameterised, so derived sizes are exposed as functions of the operand parameters.
package unsigned_sequential_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CALC cycles needed to retire every multiplier digit.
  function automatic int iter_f(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  function automatic int cnt_w_f(input int width, input int bits_per_cycle);
    return $clog2(iter_f(width, bits_per_cycle) + 1);
  endfunction

  function automatic bit params_legal(input int width, input int bits_per_cycle);
    return (bits_per_cycle >= 1) && (bits_per_cycle <= width) &&
           ((width % bits_per_cycle) == 0);
  endfunction

endpackage

// File: rtl/unsigned_sequential_multiplier_if.sv
// Operand/product handshake bundle. The master side is the producer of operands
// and consumer of products; the slave side is the multiplier.
interface unsigned_sequential_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 In_Valid_In;
  logic                 In_Ready_Out;
  logic [WIDTH-1:0]     Data_A_In;
  logic [WIDTH-1:0]     Data_B_In;
  logic                 Out_Valid_Out;
  logic                 Out_Ready_In;
  logic [2*WIDTH-1:0]   Multiplied_Result_Out;
  logic                 Busy_Out;

  modport master (
    output In_Valid_In, Data_A_In, Data_B_In, Out_Ready_In,
    input  In_Ready_Out, Out_Valid_Out, Multiplied_Result_Out, Busy_Out
  );

  modport slave (
    input  In_Valid_In, Data_A_In, Data_B_In, Out_Ready_In,
    output In_Ready_Out, Out_Valid_Out, Multiplied_Result_Out, Busy_Out
  );
endinterface

// File: rtl/unsigned_sequential_multiplier_partial_product_adder.sv
// Combinational accumulator step: acc + a_sh * digit at full 2*WIDTH width.
// Built as a chain of gated shifted adds so a Booth-recoded digit can later replace the gating.
module unsigned_sequential_multiplier_partial_product_adder #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [2*WIDTH-1:0]        a_sh,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  output logic [2*WIDTH-1:0]        acc_nxt
);
  localparam int PW = 2 * WIDTH;

  logic [BITS_PER_CYCLE:0][PW-1:0] psum;

  assign psum[0] = acc;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_row
    assign psum[i+1] = psum[i] + ((a_sh << i) & {PW{digit[i]}});
  end

  assign acc_nxt = psum[BITS_PER_CYCLE];

endmodule

// File: rtl/unsigned_sequential_multiplier.sv
// Multi-cycle unsigned multiplier: retires BITS_PER_CYCLE multiplier bits per enabled
// clock with a registered shift-add datapath, valid/ready on both sides and a global stall.
module unsigned_sequential_multiplier
  import unsigned_sequential_multiplier_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter bit EARLY_EXIT     = 1'b0
) (
  input  logic                          Clock_In,
  input  logic                          Reset_N_In,
  input  logic                          Enable_In,
  unsigned_sequential_multiplier_if.slave bus
);
  localparam int ITER  = iter_f(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_w_f(WIDTH, BITS_PER_CYCLE);
  localparam int PW    = 2 * WIDTH;

  if (!params_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
    $error("BITS_PER_CYCLE must be in 1..WIDTH and divide WIDTH");
  end

  state_e             state, state_nxt;
  logic [PW-1:0]      a_sh, acc, acc_nxt, result;
  logic [WIDTH-1:0]   b_sh, b_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               fire_in, fire_out, last_iter, zero_rest, finish;

  assign fire_in   = (state == IDLE) && bus.In_Valid_In  && Enable_In;
  assign fire_out  = (state == DONE) && bus.Out_Ready_In && Enable_In;
  assign b_nxt     = b_sh >> BITS_PER_CYCLE;
  assign last_iter = (cnt == CNT_W'(ITER - 1));
  // Early exit looks at the post-shift multiplier, so at least one CALC cycle always runs.
  assign zero_rest = EARLY_EXIT && (b_nxt == '0);
  assign finish    = (state == CALC) && Enable_In && (last_iter || zero_rest);

  unsigned_sequential_multiplier_partial_product_adder #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_partial_product_adder (
    .acc     (acc),
    .a_sh    (a_sh),
    .digit   (b_sh[BITS_PER_CYCLE-1:0]),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_in)  state_nxt = CALC;
      CALC:    if (finish)   state_nxt = DONE;
      DONE:    if (fire_out) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.In_Ready_Out  = (state == IDLE);
    bus.Busy_Out      = (state != IDLE);
    bus.Out_Valid_Out = (state == DONE);
  end

  assign bus.Multiplied_Result_Out = result;

  // Result only loads on the finishing add, so an aborted or in-flight product never shows.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (Enable_In) begin
      if (fire_in) begin
        a_sh <= {{WIDTH{1'b0}}, bus.Data_A_In};
        b_sh <= bus.Data_B_In;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == CALC) begin
        a_sh <= a_sh << BITS_PER_CYCLE;
        b_sh <= b_nxt;
        acc  <= acc_nxt;
        cnt  <= cnt + 1'b1;
        if (finish) result <= acc_nxt;
      end
    end
  end

endmodule
